rr_sel3: RTL

Round-robin source sequencer that sits directly upstream of the 3:1 mux. It arbitrates among three requesting sources and generates the 2-bit `sel` code the mux consumes. It also registers the winning source's data behind a valid/ready output handshake. The mux's `d0`/`d1`/`d2` ordering and `sel` encoding (00→d0, 01→d1, 10→d2) are preserved; `sel` never takes the value 11.

---
 rtl/rr_sel3.sv | 114 +++++++++++
 1 files changed

// File: rtl/rr_sel3.sv
// rtl/rr_sel3.sv - round-robin 3-source sequencer producing the 3:1 mux select and a registered output slot
module rr_sel3 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [2:0]       grant,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       last;
  logic [1:0]       win;
  logic [WIDTH-1:0] win_data;
  logic             slot_free;
  logic             load;

  // out_valid is a direct view of the registered slot state
  assign out_valid = (state == FULL);

  // slot can take a new item when empty or being drained this cycle
  assign slot_free = !out_valid || out_ready;

  // no grant may be issued while reset is held, whatever req shows
  assign load = slot_free && (req != 3'b000) && !rst;

  // pick the first requester in rotating order starting just after last
  always_comb begin
    win = 2'd0;
    case (last)
      2'd0: begin
        if (req[1])      win = 2'd1;
        else if (req[2]) win = 2'd2;
        else             win = 2'd0;
      end
      2'd1: begin
        if (req[2])      win = 2'd2;
        else if (req[0]) win = 2'd0;
        else             win = 2'd1;
      end
      default: begin
        if (req[0])      win = 2'd0;
        else if (req[1]) win = 2'd1;
        else             win = 2'd2;
      end
    endcase
  end

  // one-hot grant for the winner, only when an item is actually loaded
  always_comb begin
    grant = 3'b000;
    if (load) begin
      case (win)
        2'd0:    grant = 3'b001;
        2'd1:    grant = 3'b010;
        default: grant = 3'b100;
      endcase
    end
  end

  // data steering for the winner; kept off the grant path on purpose
  always_comb begin
    win_data = d0;
    case (win)
      2'd0:    win_data = d0;
      2'd1:    win_data = d1;
      default: win_data = d2;
    endcase
  end

  // slot state, captured data, select code and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      out   <= '0;
      sel   <= 2'b00;
      last  <= 2'd2;
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state <= FULL;
            out   <= win_data;
            sel   <= win;
            last  <= win;
          end
        end
        default: begin
          if (load) begin
            state <= FULL;
            out   <= win_data;
            sel   <= win;
            last  <= win;
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
      endcase
    end
  end

endmodule
